fifo_wr_arbiter: RTL

Round-robin, burst-locking arbiter that shares the single FIFO write port among `N_REQ` producers. It sits directly in front of the FIFO write side and drives `fifo_wr_en` / `fifo_wr_data` from the winning requester. It gates every grant on `fifo_full`, so an arbitrated write is never lost. Optional statistics counters track accepted writes per requester and FIFO write errors.

---
 rtl/fifo_param_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_param_pkg.sv
// FIFO-wide parameters plus the shared types used by the write-port arbiter.
// The arbiter statistics counters are built only when FIFO_ARB_STATS_EN is defined.
package fifo_param_pkg;

  localparam int FIFO_WIDTH        = 32;

  localparam int FIFO_ARB_NREQ_MAX = 16;
  localparam int FIFO_ARB_CNT_W    = 16;
  localparam int FIFO_ARB_IDX_W    = $clog2(FIFO_ARB_NREQ_MAX);
  // Burst counter is held at a fixed width so the state struct is parameter-free;
  // this caps MAX_BURST at 255.
  localparam int FIFO_ARB_BCNT_W   = 8;

  typedef struct packed {
    logic [FIFO_ARB_IDX_W-1:0]  owner;
    logic                       owner_vld;
    logic [FIFO_ARB_BCNT_W-1:0] burst_cnt;
    logic [FIFO_ARB_IDX_W-1:0]  rr_ptr;
  } fifo_arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit scanning upward from rr_ptr, modulo N.
module rr_pick
  import fifo_param_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [FIFO_ARB_IDX_W-1:0] rr_ptr,
  output logic [FIFO_ARB_IDX_W-1:0] sel,
  output logic                      found
);

  logic [FIFO_ARB_NREQ_MAX-1:0] req_x;
  logic [FIFO_ARB_IDX_W:0]      idx;

  assign req_x = FIFO_ARB_NREQ_MAX'(req);

  // Walk from the farthest slot back to rr_ptr so the nearest hit wins last.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (FIFO_ARB_IDX_W+1)'(k);
      if (idx >= (FIFO_ARB_IDX_W+1)'(N)) idx = idx - (FIFO_ARB_IDX_W+1)'(N);
      if (req_x[idx[FIFO_ARB_IDX_W-1:0]]) begin
        sel   = idx[FIFO_ARB_IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter in front of a FIFO write port (zero-latency grant).
// Optional per-requester write / error counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_param_pkg::*;
#(
  parameter  int N_REQ     = 4,   // 2..16
  parameter  int MAX_BURST = 4,   // 1..255
  localparam int OW        = $clog2(N_REQ)
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ-1:0][FIFO_WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]                     gnt,
  output logic                                 fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]                fifo_wr_data,
  input  logic                                 fifo_full,
  input  logic                                 fifo_wr_err,
  output logic [OW-1:0]                        owner,
  output logic                                 owner_vld
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][FIFO_ARB_CNT_W-1:0] wr_cnt,
  output logic [FIFO_ARB_CNT_W-1:0]            err_cnt
`endif
);

  localparam logic [FIFO_ARB_BCNT_W-1:0] MAXB = FIFO_ARB_BCNT_W'(MAX_BURST);

  fifo_arb_state_t              st, st_nxt;
  logic [FIFO_ARB_NREQ_MAX-1:0] req_x;
  logic [FIFO_ARB_IDX_W-1:0]    scan_sel, sel;
  logic                         found, owner_hit, grant_any;

  assign req_x = FIFO_ARB_NREQ_MAX'(req);

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .rr_ptr (st.rr_ptr),
    .sel    (scan_sel),
    .found  (found)
  );

  // Owner keeps the port while it still requests and has burst budget left.
  assign owner_hit = st.owner_vld && req_x[st.owner] && (st.burst_cnt < MAXB);
  assign sel       = owner_hit ? st.owner : scan_sel;
  assign grant_any = nRST && !fifo_full && (owner_hit || found);

  always_comb begin
    gnt          = '0;
    fifo_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && sel == FIFO_ARB_IDX_W'(i)) begin
        gnt[i]       = 1'b1;
        fifo_wr_data = req_data[i];
      end
    end
  end

  assign fifo_wr_en = |gnt;

  // Full pauses the burst without terminating it: no branch fires while full.
  always_comb begin
    st_nxt = st;
    if (grant_any) begin
      if (owner_hit) begin
        st_nxt.burst_cnt = st.burst_cnt + 1'b1;
      end else begin
        st_nxt.owner     = sel;
        st_nxt.owner_vld = 1'b1;
        st_nxt.burst_cnt = FIFO_ARB_BCNT_W'(1);
        st_nxt.rr_ptr    = (sel == FIFO_ARB_IDX_W'(N_REQ-1)) ? '0 : sel + 1'b1;
      end
    end else if (!fifo_full && st.owner_vld && !req_x[st.owner]) begin
      st_nxt.owner_vld = 1'b0;
      st_nxt.burst_cnt = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) st <= '0;
    else       st <= st_nxt;
  end

  assign owner     = st.owner[OW-1:0];
  assign owner_vld = st.owner_vld;

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (gnt[i] && wr_cnt[i] != '1) wr_cnt[i] <= wr_cnt[i] + 1'b1;
      if (fifo_wr_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  logic unused_wr_err;
  assign unused_wr_err = fifo_wr_err;
`endif

endmodule
